// File: rtl/signed_serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial two's-complement subtractor.
package signed_serial_subtractor_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : signed_serial_subtractor_pkg

// File: rtl/signed_serial_subtractor_if.sv
// Start/done handshake, operand and result bundle for the serial subtractor.
interface signed_serial_subtractor_if
    import signed_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DATA_W
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             overflow;
    logic             borrow;

    modport master (
        output start, a, b,
        input  busy, done, diff, overflow, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, overflow, borrow
    );

endinterface : signed_serial_subtractor_if

// File: rtl/signed_serial_subtractor_full_adder_cell.sv
// One-bit full adder; the same cell the combinational adder replicates per bit.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_cell

// File: rtl/signed_serial_subtractor.sv
// Bit-serial a - b computed LSB first as a + ~b + 1 through a single full-adder cell.
module signed_serial_subtractor
    import signed_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    signed_serial_subtractor_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             ovf_q, ovf_d;
    logic             borrow_q, borrow_d;

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] sum_next;

    full_adder_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Sum bits enter at the MSB so the word is right-aligned after WIDTH shifts.
    assign sum_next = {fa_s, sum_sr_q[WIDTH-1:1]};

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_sr_d = sum_sr_q;
        diff_d   = diff_q;
        ovf_d    = ovf_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = ~bus.b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_sr_d = sum_next;
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // carry_q is the carry into the MSB; fa_cout is the carry out of it.
                    diff_d   = sum_next;
                    ovf_d    = carry_q ^ fa_cout;
                    borrow_d = ~fa_cout;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_sr_q <= '0;
            diff_q   <= '0;
            ovf_q    <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_sr_q <= sum_sr_d;
            diff_q   <= diff_d;
            ovf_q    <= ovf_d;
            borrow_q <= borrow_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.diff     = diff_q;
    assign bus.overflow = ovf_q;
    assign bus.borrow   = borrow_q;

endmodule : signed_serial_subtractor

// File: tb/tb_signed_serial_subtractor.sv
// Directed self-checking bench for signed_serial_subtractor with hand-computed results.
module tb_signed_serial_subtractor;

    localparam int W = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    signed_serial_subtractor_if #(.WIDTH(W)) bus ();

    signed_serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one operation; optionally pulse a stray start mid-run. Inputs are driven on negedges.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp_diff, input logic exp_ovf, input logic exp_brw,
                          input bit inject);
        int n;
        bit found;
        @(negedge clk);
        bus.a = av;
        bus.b = bv;
        bus.start = 1'b1;
        n = 0;
        found = 1'b0;
        while (!found && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
                bus.start = 1'b0;
                bus.a = ~av;
                bus.b = av;
            end
            if (inject && n == 2) begin
                bus.start = 1'b1;
                bus.a = 4'b0101;
                bus.b = 4'b0101;
            end
            if (inject && n == 3) bus.start = 1'b0;
            if (bus.done) found = 1'b1;
        end
        check({tag, "_latency"}, 32'(n), 32'(W + 1));
        check({tag, "_diff"}, 32'(bus.diff), 32'(exp_diff));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
        check({tag, "_borrow"}, 32'(bus.borrow), 32'(exp_brw));
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int extra;
        int last_done;
        int pulses;
        int overlap;

        n_checks = 0;
        n_errors = 0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_borrow", 32'(bus.borrow), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("3m5", 4'b0011, 4'b0101, 4'b1110, 1'b1 ^ 1'b1, 1'b1, 1'b0);
        run_op("7mm3", 4'b0111, 4'b1101, 4'b1010, 1'b1, 1'b1, 1'b0);
        run_op("m8m1", 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b0, 1'b0);
        run_op("m3mm5", 4'b1101, 4'b1011, 4'b0010, 1'b0, 1'b0, 1'b1);

        // The stray start during the last run must not produce a second operation.
        extra = 0;
        for (int i = 0; i < 2 * W + 4; i++) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        check("ignored_start_pulses", 32'(extra), 32'd0);
        check("ignored_start_diff", 32'(bus.diff), 32'b0010);

        // Asynchronous reset during RUN cycle 2.
        @(negedge clk);
        bus.a = 4'b0111;
        bus.b = 4'b0001;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_diff", 32'(bus.diff), 32'd0);
        check("midrst_ovf", 32'(bus.overflow), 32'd0);
        check("midrst_borrow", 32'(bus.borrow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        check("midrst_no_done", 32'(extra), 32'd0);
        run_op("0m0", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        run_op("5m5", 4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0);

        // Start held high: one result every W+2 cycles, done never overlaps busy.
        bus.a = 4'b0011;
        bus.b = 4'b0101;
        bus.start = 1'b1;
        pulses = 0;
        overlap = 0;
        last_done = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.busy && bus.done) overlap++;
            if (bus.done) begin
                pulses++;
                if (pulses == 1) check("held_first_latency", 32'(i), 32'(W + 1));
                else check("held_interval", 32'(i - last_done), 32'(W + 2));
                check("held_diff", 32'(bus.diff), 32'b1110);
                last_done = i;
            end
        end
        bus.start = 1'b0;
        check("held_pulses", 32'(pulses), 32'd3);
        check("held_overlap", 32'(overlap), 32'd0);

        for (int i = 0; i < 2 * W + 4; i++) @(negedge clk);
        check("final_idle", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_signed_serial_subtractor
